// File: rtl/rom_read_arbiter_pkg.sv
// Shared types and sizing helpers for the ROM read arbiter slice.
package rom_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      DATA = 2'd2
   } state_t;

   localparam int NUM_REQ_DEF = 4;
   localparam int IDX_W_DEF   = $clog2(NUM_REQ_DEF);

   // Never returns zero, so a requester index always has at least one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rom_read_arbiter_if.sv
// Requester-side and ROM-side signals of the arbiter, bundled as one bus.
interface rom_read_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 2,
   parameter int DATA_W  = 1
);
   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ*ADDR_W-1:0] req_addr;
   logic [NUM_REQ-1:0]        gnt;
   logic [NUM_REQ-1:0]        rsp_valid;
   logic [DATA_W-1:0]         rsp_data;
   logic                      busy;
   logic                      rom_en;
   logic [ADDR_W-1:0]         rom_addr;
   logic [DATA_W-1:0]         rom_data;

   modport slave (
      input  req, req_addr, rom_data,
      output gnt, rsp_valid, rsp_data, busy, rom_en, rom_addr
   );

   modport master (
      output req, req_addr, rom_data,
      input  gnt, rsp_valid, rsp_data, busy, rom_en, rom_addr
   );
endinterface

// File: rtl/rom_read_arbiter_rr_picker.sv
// Round-robin picker: first set req bit at or above ptr, wrapping modulo NUM_REQ.
module rr_picker
   import rom_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = idx_w(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic               found,
   output logic [IDX_W-1:0]   winner
);

   int               idx;
   logic [IDX_W-1:0] idx_s;

   // Walk from the farthest candidate back to ptr so the closest one wins last.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      idx    = 0;
      idx_s  = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         idx   = (int'(ptr) + k) % NUM_REQ;
         idx_s = IDX_W'(idx);
         if (req[idx_s]) begin
            found  = 1'b1;
            winner = idx_s;
         end
      end
   end

endmodule

// File: rtl/rom_read_arbiter.sv
// Round-robin arbiter sharing one synchronous-read ROM among NUM_REQ requesters.
module rom_read_arbiter
   import rom_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ADDR_W  = 2,
   parameter int DATA_W  = 1
) (
   input logic              clk,
   input logic              rst,
   rom_read_arbiter_if.slave bus
);

   localparam int IDX_W = idx_w(NUM_REQ);

   state_t             state, state_nxt;
   logic [IDX_W-1:0]   owner, rr_ptr, winner;
   logic               found;
   logic               arb_now;
   logic [ADDR_W-1:0]  rom_addr_r, sel_addr;
   logic [DATA_W-1:0]  rsp_data_r;
   logic [NUM_REQ-1:0] rsp_valid_r;

   function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
      logic [NUM_REQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] idx);
      return (idx == IDX_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
   endfunction

   rr_picker #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_picker (
      .req    (bus.req),
      .ptr    (rr_ptr),
      .found  (found),
      .winner (winner)
   );

   always_comb begin
      sel_addr = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (winner == IDX_W'(i)) sel_addr = bus.req_addr[i*ADDR_W +: ADDR_W];
      end
   end

   // Arbitration only happens when leaving IDLE or DATA; req is ignored in READ.
   always_comb begin
      state_nxt = state;
      arb_now   = 1'b0;
      case (state)
         IDLE: begin
            if (found) begin
               state_nxt = READ;
               arb_now   = 1'b1;
            end
         end
         READ: state_nxt = DATA;
         DATA: begin
            if (found) begin
               state_nxt = READ;
               arb_now   = 1'b1;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         owner       <= '0;
         rr_ptr      <= '0;
         rom_addr_r  <= '0;
         rsp_data_r  <= '0;
         rsp_valid_r <= '0;
      end else begin
         state       <= state_nxt;
         rsp_valid_r <= (state == DATA) ? onehot(owner) : '0;
         if (state == DATA) rsp_data_r <= bus.rom_data;
         if (arb_now) begin
            owner      <= winner;
            rr_ptr     <= next_ptr(winner);
            rom_addr_r <= sel_addr;
         end
      end
   end

   assign bus.gnt       = (state == READ) ? onehot(owner) : '0;
   assign bus.rom_en    = (state == READ);
   assign bus.busy      = (state == READ) || (state == DATA);
   assign bus.rom_addr  = rom_addr_r;
   assign bus.rsp_valid = rsp_valid_r;
   assign bus.rsp_data  = rsp_data_r;

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Directed bench for rom_read_arbiter with a sync-read ROM model returning addr[0].
module tb_rom_read_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   compared = 0;
   int   failed   = 0;

   always #5 clk = ~clk;

   rom_read_arbiter_if #(.NUM_REQ(4), .ADDR_W(2), .DATA_W(1)) bus ();

   rom_read_arbiter #(.NUM_REQ(4), .ADDR_W(2), .DATA_W(1)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial bus.rom_data = 1'b0;
   always @(posedge clk) begin
      if (bus.rom_en) bus.rom_data <= bus.rom_addr[0];
   end

   logic [3:0] pk_req;
   logic [1:0] pk_ptr;
   logic       pk_found;
   logic [1:0] pk_winner;

   rr_picker #(.NUM_REQ(4), .IDX_W(2)) u_pick (
      .req    (pk_req),
      .ptr    (pk_ptr),
      .found  (pk_found),
      .winner (pk_winner)
   );

   typedef struct {
      logic        rst;
      logic [3:0]  req;
      logic [7:0]  addr;
      logic [12:0] exp;
   } vec_t;

   typedef struct {
      logic [3:0] req;
      logic [1:0] ptr;
      logic [2:0] exp;
   } pvec_t;

   vec_t  vecs[$];
   pvec_t pvecs[$];

   task automatic add(input logic r, input logic [3:0] rq, input logic [7:0] a,
                      input logic [3:0] g, input logic [3:0] rv, input logic rd,
                      input logic b, input logic en, input logic [1:0] ra);
      vec_t v;
      v.rst  = r;
      v.req  = rq;
      v.addr = a;
      v.exp  = {g, rv, rd, b, en, ra};
      vecs.push_back(v);
   endtask

   task automatic padd(input logic [3:0] rq, input logic [1:0] p, input logic f,
                       input logic [1:0] w);
      pvec_t v;
      v.req = rq;
      v.ptr = p;
      v.exp = {f, w};
      pvecs.push_back(v);
   endtask

   function automatic logic [12:0] obs();
      return {bus.gnt, bus.rsp_valid, bus.rsp_data, bus.busy, bus.rom_en, bus.rom_addr};
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      compared++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %b, expected %b", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   localparam logic [7:0] AD = 8'b00_11_10_01;
   localparam logic [7:0] SA = 8'b00_11_00_00;

   initial begin
      // Picker vectors: {req, ptr} -> {found, winner}
      padd(4'b0000, 2'd2, 1'b0, 2'd0);
      padd(4'b1010, 2'd0, 1'b1, 2'd1);
      padd(4'b1010, 2'd2, 1'b1, 2'd3);
      padd(4'b1010, 2'd3, 1'b1, 2'd3);
      padd(4'b0001, 2'd3, 1'b1, 2'd0);
      padd(4'b1111, 2'd1, 1'b1, 2'd1);
      padd(4'b0110, 2'd3, 1'b1, 2'd1);
      padd(4'b1000, 2'd0, 1'b1, 2'd3);

      // Reset with all requesting, then eight round-robin reads
      add(1, 4'b1111, AD, 4'b0000, 4'b0000, 0, 0, 0, 2'd0);
      add(1, 4'b1111, AD, 4'b0000, 4'b0000, 0, 0, 0, 2'd0);
      add(0, 4'b1111, AD, 4'b0001, 4'b0000, 0, 1, 1, 2'd1);
      add(0, 4'b1111, AD, 4'b0000, 4'b0000, 0, 1, 0, 2'd1);
      add(0, 4'b1111, AD, 4'b0010, 4'b0001, 1, 1, 1, 2'd2);
      add(0, 4'b1111, AD, 4'b0000, 4'b0000, 1, 1, 0, 2'd2);
      add(0, 4'b1111, AD, 4'b0100, 4'b0010, 0, 1, 1, 2'd3);
      add(0, 4'b1111, AD, 4'b0000, 4'b0000, 0, 1, 0, 2'd3);
      add(0, 4'b1111, AD, 4'b1000, 4'b0100, 1, 1, 1, 2'd0);
      add(0, 4'b1111, AD, 4'b0000, 4'b0000, 1, 1, 0, 2'd0);
      add(0, 4'b1111, AD, 4'b0001, 4'b1000, 0, 1, 1, 2'd1);
      add(0, 4'b1111, AD, 4'b0000, 4'b0000, 0, 1, 0, 2'd1);
      add(0, 4'b1111, AD, 4'b0010, 4'b0001, 1, 1, 1, 2'd2);
      add(0, 4'b1111, AD, 4'b0000, 4'b0000, 1, 1, 0, 2'd2);
      add(0, 4'b1111, AD, 4'b0100, 4'b0010, 0, 1, 1, 2'd3);
      add(0, 4'b1111, AD, 4'b0000, 4'b0000, 0, 1, 0, 2'd3);
      add(0, 4'b1111, AD, 4'b1000, 4'b0100, 1, 1, 1, 2'd0);
      add(0, 4'b1111, AD, 4'b0000, 4'b0000, 1, 1, 0, 2'd0);
      add(0, 4'b0000, AD, 4'b0000, 4'b1000, 0, 0, 0, 2'd0);
      add(0, 4'b0000, AD, 4'b0000, 4'b0000, 0, 0, 0, 2'd0);
      // Single read from requester 2 at address 3
      add(0, 4'b0100, SA, 4'b0100, 4'b0000, 0, 1, 1, 2'd3);
      add(0, 4'b0000, SA, 4'b0000, 4'b0000, 0, 1, 0, 2'd3);
      add(0, 4'b0000, SA, 4'b0000, 4'b0100, 1, 0, 0, 2'd3);
      add(0, 4'b0000, SA, 4'b0000, 4'b0000, 1, 0, 0, 2'd3);

      for (int i = 0; i < pvecs.size(); i++) begin
         pk_req = pvecs[i].req;
         pk_ptr = pvecs[i].ptr;
         #1;
         check($sformatf("picker[%0d]", i), {13'd0, pk_found, pk_winner}, {13'd0, pvecs[i].exp});
      end

      for (int i = 0; i < vecs.size(); i++) begin
         rst          = vecs[i].rst;
         bus.req      = vecs[i].req;
         bus.req_addr = vecs[i].addr;
         step();
         check($sformatf("row[%0d]", i), {3'd0, obs()}, {3'd0, vecs[i].exp});
      end

      // Back-to-back: requester 0 stays high after its grant
      bus.req = 4'b0001; bus.req_addr = 8'b00_00_00_01;
      step();
      check("b2b_gnt", {12'd0, bus.gnt}, 16'h0001);
      step();
      check("b2b_data_phase", {8'd0, bus.gnt, bus.rsp_valid}, 16'h0000);
      step();
      check("b2b_rsp_and_gnt", {7'd0, bus.gnt, bus.rsp_valid, bus.rsp_data}, {7'd0, 4'b0001, 4'b0001, 1'b1});
      bus.req = 4'b0000;
      step();
      step();
      check("b2b_second_rsp", {6'd0, bus.gnt, bus.rsp_valid, bus.rsp_data, bus.busy},
            {6'd0, 4'b0000, 4'b0001, 1'b1, 1'b0});

      // Reset during DATA after granting requester 1 (rr_ptr moves to 2)
      bus.req = 4'b0010; bus.req_addr = 8'b00_00_10_00;
      step();
      check("rst_pre_gnt", {12'd0, bus.gnt}, 16'h0002);
      bus.req = 4'b0000;
      step();
      rst = 1'b1;
      step();
      check("rst_mid_outputs", {3'd0, obs()}, 16'h0000);
      rst = 1'b0;
      step();
      check("rst_no_rsp", {11'd0, bus.rsp_valid, bus.busy}, 16'h0000);
      bus.req = 4'b1010; bus.req_addr = 8'b11_00_10_00;
      step();
      check("rst_ptr_zero_gnt", {10'd0, bus.gnt, bus.rom_addr}, {10'd0, 4'b0010, 2'd2});
      bus.req = 4'b0000;
      step();
      step();
      check("rst_after_rsp", {11'd0, bus.rsp_valid, bus.rsp_data}, {11'd0, 4'b0010, 1'b0});

      // Withdrawal: requester 1 pulses while requester 0 is in READ
      bus.req = 4'b0001; bus.req_addr = 8'b00_00_00_01;
      step();
      check("wd_gnt0", {12'd0, bus.gnt}, 16'h0001);
      bus.req = 4'b0010;
      step();
      check("wd_data_no_gnt", {12'd0, bus.gnt}, 16'h0000);
      bus.req = 4'b0000;
      step();
      check("wd_idle_rsp", {7'd0, bus.gnt, bus.busy, bus.rsp_valid}, {7'd0, 4'b0000, 1'b0, 4'b0001});
      step();
      check("wd_stays_idle", {11'd0, bus.gnt, bus.busy}, 16'h0000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
      $finish;
   end

endmodule
